// File: rtl/mc_sequencer_pkg.sv
// rtl/mc_sequencer_pkg.sv - shared state encodings and defaults for the multicycle sequencer
package mc_sequencer_pkg;

    localparam int WAIT_MAX_DEFAULT = 16;
    localparam int WAIT_CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - counts unacknowledged memory wait cycles and flags the last allowed one
module mc_wait_timer
    import mc_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] count;

    // expired marks the WAIT_MAX-th waiting cycle; an ack in that same cycle still wins
    assign expired = (count == WAIT_CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle instruction sequencer with memory wait timeout and retire counter
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ack,
    input  logic        dmem_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        branch,
    input  logic        unknown_op,
    input  logic        take_branch,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        trap,
    output logic [2:0]  state_o,
    output logic [31:0] instret
);

    state_t      state;
    logic [31:0] instret_q;
    logic        waiting;
    logic        acked;
    logic        expired;

    assign waiting = is_wait_state(state);

    always_comb begin
        acked = 1'b0;
        if (state == ST_FETCH) begin
            acked = imem_ack;
        end else if (state == ST_MEM) begin
            acked = dmem_ready;
        end
    end

    // Cleared whenever not waiting, so the count is zero on every entry to FETCH or MEM
    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting || acked),
        .enable  (waiting && !acked),
        .expired (expired)
    );

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_EXEC: begin
                    if (branch) begin
                        pc_we  = 1'b1;
                        pc_sel = take_branch;
                    end else if (!mem_read && !mem_write && !reg_write) begin
                        pc_we = 1'b1;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = mem_write;
                    pc_we    = dmem_ready && !mem_read;
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            instret_q <= '0;
        end else begin
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state <= ST_DECODE;
                    end else if (expired) begin
                        state <= ST_TRAP;
                    end
                end
                ST_DECODE: state <= unknown_op ? ST_TRAP : ST_EXEC;
                ST_EXEC: begin
                    if (branch) begin
                        state <= ST_FETCH;
                    end else if (mem_read || mem_write) begin
                        state <= ST_MEM;
                    end else if (reg_write) begin
                        state <= ST_WB;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        state <= mem_read ? ST_WB : ST_FETCH;
                    end else if (expired) begin
                        state <= ST_TRAP;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                default: state <= ST_TRAP;
            endcase
        end
    end

    assign trap    = (state == ST_TRAP);
    assign state_o = state;
    assign instret = instret_q;

endmodule
